// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte producers.
// Handshake: a producer holds req_i[i] with its byte until ack_o[i] pulses; ack_o is one-hot, one cycle.
module uart_tx_sched #(
  parameter int NREQ      = 4,
  parameter int EN_HOLD   = 4,
  parameter int TO_CYCLES = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic              tx_done_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              tx_en_o,
  output logic [7:0]        tx_data_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [1:0]        state_o
);

  localparam int PW = $clog2(NREQ);
  localparam int HW = $clog2(EN_HOLD);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, ACK = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            err_q, err_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [23:0]     wd_q, wd_d;
  logic            sync1_q, sync2_q, prev_q;
  logic            done_evt;

  logic            hi_found, any_found;
  logic [PW-1:0]   hi_idx, any_idx, sel_idx;
  logic [7:0]      sel_data;

  assign done_evt = sync2_q & ~prev_q;

  // Lowest pending index at or above ptr wins; otherwise wrap to the lowest pending index.
  always_comb begin
    hi_found  = 1'b0;
    hi_idx    = '0;
    any_found = 1'b0;
    any_idx   = '0;
    sel_data  = 8'h00;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        any_found = 1'b1;
        any_idx   = PW'(i);
        if (PW'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = PW'(i);
        end
      end
    end
    sel_idx = hi_found ? hi_idx : any_idx;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == sel_idx) sel_data = req_data_i[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    err_d     = err_q;
    hold_d    = hold_q;
    wd_d      = wd_q;
    case (state_q)
      IDLE: begin
        if (any_found) begin
          grant_d   = NREQ'(1) << sel_idx;
          gidx_d    = sel_idx;
          tx_data_d = sel_data;
          hold_d    = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (hold_q == HW'(EN_HOLD - 1)) begin
          state_d = WAIT;
          wd_d    = 24'd1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      WAIT: begin
        // wd_q numbers the current WAIT cycle from 1, so expiry lands ACK on cycle TO_CYCLES.
        if (done_evt) begin
          state_d = ACK;
        end else if (wd_q == 24'(TO_CYCLES - 1)) begin
          state_d = ACK;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 24'd1;
        end
      end
      ACK: begin
        grant_d = '0;
        ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        err_d   = 1'b0;
        hold_d  = '0;
        wd_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      grant_q   <= '0;
      tx_data_q <= 8'h00;
      err_q     <= 1'b0;
      hold_q    <= '0;
      wd_q      <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
      hold_q    <= hold_d;
      wd_q      <= wd_d;
      sync1_q   <= tx_done_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
    end
  end

  assign grant_o   = grant_q;
  assign tx_data_o = tx_data_q;
  assign tx_en_o   = (state_q == LOAD);
  assign busy_o    = (state_q != IDLE);
  assign ack_o     = (state_q == ACK) ? grant_q : '0;
  assign err_o     = (state_q == ACK) & err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: main instance plus a short-watchdog instance.
module tb_uart_tx_sched;

  localparam int NREQ    = 4;
  localparam int EN_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  req, ack, grant;
  logic [31:0] req_data;
  logic        tx_done, tx_en, busy, err;
  logic [7:0]  tx_data;
  logic [1:0]  state;

  logic [3:0]  req_wd, ack_wd, grant_wd;
  logic [31:0] req_data_wd;
  logic        tx_done_wd, tx_en_wd, busy_wd, err_wd;
  logic [7:0]  tx_data_wd;
  logic [1:0]  state_wd;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_sched #(.NREQ(NREQ), .EN_HOLD(EN_HOLD), .TO_CYCLES(1000)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_data_i(req_data), .tx_done_i(tx_done),
    .ack_o(ack), .grant_o(grant), .tx_en_o(tx_en), .tx_data_o(tx_data), .busy_o(busy),
    .err_o(err), .state_o(state)
  );

  uart_tx_sched #(.NREQ(NREQ), .EN_HOLD(EN_HOLD), .TO_CYCLES(50)) dut_wd (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_wd), .req_data_i(req_data_wd), .tx_done_i(tx_done_wd),
    .ack_o(ack_wd), .grant_o(grant_wd), .tx_en_o(tx_en_wd), .tx_data_o(tx_data_wd), .busy_o(busy_wd),
    .err_o(err_wd), .state_o(state_wd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int lat);
    lat = 0;
    while (grant == 4'd0 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // One full transfer on the main instance: TxDone rises gap cycles into WAIT.
  task automatic serve(input int idx, input logic [7:0] data, input int gap);
    int lat;
    int en_len;
    wait_grant(lat);
    chk("grant", 32'(grant), 32'd1 << idx);
    chk("tx_data", 32'(tx_data), 32'(data));
    chk("busy", 32'(busy), 32'd1);
    en_len = 0;
    while (tx_en && en_len < 20) begin
      en_len++;
      tick();
    end
    chk("tx_en_len", 32'(en_len), 32'(EN_HOLD));
    repeat (gap) tick();
    tx_done = 1'b1;
    repeat (2) tick();
    chk("ack_early", 32'(ack), 32'd0);
    tick();
    chk("ack", 32'(ack), 32'd1 << idx);
    chk("err", 32'(err), 32'd0);
    chk("tx_data_hold", 32'(tx_data), 32'(data));
    tx_done = 1'b0;
    tick();
    chk("ack_once", 32'(ack), 32'd0);
  endtask

  initial begin
    int lat;
    logic seen_ack;
    req = '0; req_data = '0; tx_done = 1'b0;
    req_wd = '0; req_data_wd = '0; tx_done_wd = 1'b0;

    #12;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single request: grant one cycle after req, TxDone 300 cycles after TxEn rises.
    req = 4'b0010;
    req_data = 32'h0000_A500;
    wait_grant(lat);
    chk("single_latency", 32'(lat), 32'd1);
    serve(1, 8'hA5, 296);
    req = 4'b0000;
    tick();
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_grant", 32'(grant), 32'd0);

    // Round robin from ptr=0 with all requesters pending, then wrap/skip on 1001.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    req_data = 32'h1312_1110;
    req = 4'b1111;
    serve(0, 8'h10, 4);
    serve(1, 8'h11, 4);
    serve(2, 8'h12, 4);
    serve(3, 8'h13, 4);
    req = 4'b1001;
    serve(0, 8'h10, 4);
    serve(3, 8'h13, 4);
    req = 4'b0000;
    tick();

    // Watchdog on the TO_CYCLES=50 instance with TxDone held low.
    req_wd = 4'b0001;
    req_data_wd = 32'h0000_005A;
    tick();
    chk("wd_grant", 32'(grant_wd), 32'd1);
    chk("wd_tx_data", 32'(tx_data_wd), 32'h5A);
    repeat (4) tick();
    chk("wd_wait1_tx_en", 32'(tx_en_wd), 32'd0);
    chk("wd_wait1_state", 32'(state_wd), 32'd2);
    repeat (48) tick();
    chk("wd_wait49_state", 32'(state_wd), 32'd2);
    chk("wd_wait49_ack", 32'(ack_wd), 32'd0);
    tick();
    chk("wd_ack", 32'(ack_wd), 32'd1);
    chk("wd_err", 32'(err_wd), 32'd1);
    req_wd = 4'b0000;
    tick();
    chk("wd_ack_clr", 32'(ack_wd), 32'd0);
    chk("wd_err_clr", 32'(err_wd), 32'd0);
    chk("wd_busy_clr", 32'(busy_wd), 32'd0);
    req_wd = 4'b0100;
    req_data_wd = 32'h00C7_0000;
    tick();
    chk("wd_next_grant", 32'(grant_wd), 32'd4);
    chk("wd_next_data", 32'(tx_data_wd), 32'hC7);
    repeat (7) tick();
    tx_done_wd = 1'b1;
    repeat (3) tick();
    chk("wd_next_ack", 32'(ack_wd), 32'd4);
    chk("wd_next_err", 32'(err_wd), 32'd0);
    tx_done_wd = 1'b0;
    req_wd = 4'b0000;

    // Stale TxDone held high across grant; req withdrawn and data changed in LOAD.
    tx_done = 1'b1;
    repeat (5) tick();
    req = 4'b0100;
    req_data = 32'h00C3_0000;
    tick();
    chk("stale_grant", 32'(grant), 32'd4);
    chk("stale_data", 32'(tx_data), 32'hC3);
    tick();
    req = 4'b0000;
    req_data = 32'hFFFF_FFFF;
    repeat (3) tick();
    chk("stale_wait_state", 32'(state), 32'd2);
    seen_ack = 1'b0;
    repeat (20) begin
      tick();
      if (ack != 4'd0) seen_ack = 1'b1;
    end
    chk("stale_no_ack", 32'(seen_ack), 32'd0);
    chk("stale_data_held", 32'(tx_data), 32'hC3);
    tx_done = 1'b0;
    repeat (4) tick();
    chk("stale_low_no_ack", 32'(ack), 32'd0);
    tx_done = 1'b1;
    repeat (3) tick();
    chk("stale_ack", 32'(ack), 32'd4);
    chk("stale_err", 32'(err), 32'd0);
    chk("stale_data_ack", 32'(tx_data), 32'hC3);
    tx_done = 1'b0;
    tick();
    chk("stale_grant_clr", 32'(grant), 32'd0);

    // Reset in WAIT: outputs clear at once and ptr restarts at 0.
    req = 4'b1010;
    req_data = 32'h2100_2300;
    tick();
    chk("rw_grant", 32'(grant), 32'd8);
    repeat (6) tick();
    chk("rw_wait_state", 32'(state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_grant_rst", 32'(grant), 32'd0);
    chk("rw_busy_rst", 32'(busy), 32'd0);
    chk("rw_tx_en_rst", 32'(tx_en), 32'd0);
    chk("rw_ack_rst", 32'(ack), 32'd0);
    chk("rw_err_rst", 32'(err), 32'd0);
    chk("rw_state_rst", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rw_first_grant", 32'(grant), 32'd2);
    chk("rw_first_data", 32'(tx_data), 32'h23);
    repeat (6) tick();
    tx_done = 1'b1;
    repeat (3) tick();
    chk("rw_ack", 32'(ack), 32'd2);
    req = 4'b0000;
    tx_done = 1'b0;
    repeat (2) tick();
    chk("rw_idle", 32'(state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
